// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX operand stage with forwarding and load-use detection
module ex_operand_stage #(
    parameter int NB_REG       = 32,
    parameter int NB_ADDR      = 5,
    parameter int NB_ALU_CTRLI = 4
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_stall,
    input  logic                    i_flush,
    input  logic                    i_valid,
    input  logic [NB_REG-1:0]       i_rs_data,
    input  logic [NB_REG-1:0]       i_rt_data,
    input  logic [NB_REG-1:0]       i_imm,
    input  logic [4:0]              i_shamt,
    input  logic [NB_ADDR-1:0]      i_rs_addr,
    input  logic [NB_ADDR-1:0]      i_rt_addr,
    input  logic [NB_ADDR-1:0]      i_wb_addr,
    input  logic [NB_ALU_CTRLI-1:0] i_alu_op,
    input  logic                    i_a_sel,
    input  logic [1:0]              i_b_sel,
    input  logic                    i_reg_write,
    input  logic                    i_mem_read,
    input  logic                    i_mem_write,
    input  logic                    i_mem_to_reg,
    input  logic                    i_exmem_reg_write,
    input  logic [NB_ADDR-1:0]      i_exmem_wb_addr,
    input  logic [NB_REG-1:0]       i_exmem_result,
    input  logic                    i_memwb_reg_write,
    input  logic [NB_ADDR-1:0]      i_memwb_wb_addr,
    input  logic [NB_REG-1:0]       i_memwb_data,
    output logic [NB_REG-1:0]       o_a,
    output logic [NB_REG-1:0]       o_b,
    output logic [NB_ALU_CTRLI-1:0] o_alu_op,
    output logic [NB_REG-1:0]       o_store_data,
    output logic [NB_ADDR-1:0]      o_wb_addr,
    output logic                    o_reg_write,
    output logic                    o_mem_read,
    output logic                    o_mem_write,
    output logic                    o_mem_to_reg,
    output logic                    o_valid,
    output logic                    o_load_use
);

    logic [NB_REG-1:0]       r_rs_data;
    logic [NB_REG-1:0]       r_rt_data;
    logic [NB_REG-1:0]       r_imm;
    logic [4:0]              r_shamt;
    logic [NB_ADDR-1:0]      r_rs_addr;
    logic [NB_ADDR-1:0]      r_rt_addr;
    logic [NB_ADDR-1:0]      r_wb_addr;
    logic [NB_ALU_CTRLI-1:0] r_alu_op;
    logic                    r_a_sel;
    logic [1:0]              r_b_sel;
    logic                    r_reg_write;
    logic                    r_mem_read;
    logic                    r_mem_write;
    logic                    r_mem_to_reg;
    logic                    r_valid;

    logic [NB_REG-1:0]       w_fwd_rs;
    logic [NB_REG-1:0]       w_fwd_rt;

    // Stage register: reset and flush both load an all-zero bubble; flush beats stall
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset || i_flush) begin
            r_rs_data    <= '0;
            r_rt_data    <= '0;
            r_imm        <= '0;
            r_shamt      <= '0;
            r_rs_addr    <= '0;
            r_rt_addr    <= '0;
            r_wb_addr    <= '0;
            r_alu_op     <= '0;
            r_a_sel      <= 1'b0;
            r_b_sel      <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_valid      <= 1'b0;
        end else if (!i_stall) begin
            r_rs_data    <= i_rs_data;
            r_rt_data    <= i_rt_data;
            r_imm        <= i_imm;
            r_shamt      <= i_shamt;
            r_rs_addr    <= i_rs_addr;
            r_rt_addr    <= i_rt_addr;
            r_wb_addr    <= i_wb_addr;
            r_alu_op     <= i_alu_op;
            r_a_sel      <= i_a_sel;
            r_b_sel      <= i_b_sel;
            r_reg_write  <= i_reg_write;
            r_mem_read   <= i_mem_read;
            r_mem_write  <= i_mem_write;
            r_mem_to_reg <= i_mem_to_reg;
            r_valid      <= i_valid;
        end
    end

    // Forward rs: the younger EX/MEM result wins over MEM/WB; r0 is hardwired zero
    always_comb begin
        w_fwd_rs = r_rs_data;
        if (r_rs_addr != '0 && i_exmem_reg_write && i_exmem_wb_addr == r_rs_addr)
            w_fwd_rs = i_exmem_result;
        else if (r_rs_addr != '0 && i_memwb_reg_write && i_memwb_wb_addr == r_rs_addr)
            w_fwd_rs = i_memwb_data;
    end

    // Forward rt with the same priority as rs
    always_comb begin
        w_fwd_rt = r_rt_data;
        if (r_rt_addr != '0 && i_exmem_reg_write && i_exmem_wb_addr == r_rt_addr)
            w_fwd_rt = i_exmem_result;
        else if (r_rt_addr != '0 && i_memwb_reg_write && i_memwb_wb_addr == r_rt_addr)
            w_fwd_rt = i_memwb_data;
    end

    // ALU operand muxes; shifts take the shifted value from rt on the A side
    always_comb begin
        o_a = r_a_sel ? w_fwd_rt : w_fwd_rs;
        o_b = w_fwd_rt;
        case (r_b_sel)
            2'd0: o_b = w_fwd_rt;
            2'd1: o_b = r_imm;
            2'd2: o_b = {{(NB_REG-5){1'b0}}, r_shamt};
            2'd3: o_b = w_fwd_rs;
            default: o_b = w_fwd_rt;
        endcase
    end

    assign o_store_data = w_fwd_rt;
    assign o_alu_op     = r_alu_op;
    assign o_wb_addr    = r_wb_addr;
    assign o_valid      = r_valid;
    assign o_reg_write  = r_reg_write  & r_valid;
    assign o_mem_read   = r_mem_read   & r_valid;
    assign o_mem_write  = r_mem_write  & r_valid;
    assign o_mem_to_reg = r_mem_to_reg & r_valid;

    // A load here whose destination feeds the instruction in decode must stall it a cycle
    assign o_load_use = i_valid & r_valid & r_mem_read & (r_wb_addr != '0) &
                        ((r_wb_addr == i_rs_addr) | (r_wb_addr == i_rt_addr));

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - randomized and directed bench for ex_operand_stage
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        i_reset, i_stall, i_flush, i_valid;
    logic [31:0] i_rs_data, i_rt_data, i_imm;
    logic [4:0]  i_shamt, i_rs_addr, i_rt_addr, i_wb_addr;
    logic [3:0]  i_alu_op;
    logic        i_a_sel;
    logic [1:0]  i_b_sel;
    logic        i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg;
    logic        i_exmem_reg_write, i_memwb_reg_write;
    logic [4:0]  i_exmem_wb_addr, i_memwb_wb_addr;
    logic [31:0] i_exmem_result, i_memwb_data;
    logic [31:0] o_a, o_b, o_store_data;
    logic [3:0]  o_alu_op;
    logic [4:0]  o_wb_addr;
    logic        o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_valid, o_load_use;

    int checks   = 0;
    int failures = 0;

    // Reference state: one record of what the stage holds
    typedef struct {
        logic [31:0] rs_data, rt_data, imm;
        logic [4:0]  shamt, rs_addr, rt_addr, wb_addr;
        logic [3:0]  alu_op;
        logic        a_sel;
        logic [1:0]  b_sel;
        logic        rw, mr, mw, m2r, v;
    } slot_t;
    slot_t m;

    ex_operand_stage dut (
        .i_clock(clk), .i_reset(i_reset), .i_stall(i_stall), .i_flush(i_flush),
        .i_valid(i_valid), .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_imm(i_imm),
        .i_shamt(i_shamt), .i_rs_addr(i_rs_addr), .i_rt_addr(i_rt_addr),
        .i_wb_addr(i_wb_addr), .i_alu_op(i_alu_op), .i_a_sel(i_a_sel), .i_b_sel(i_b_sel),
        .i_reg_write(i_reg_write), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .i_mem_to_reg(i_mem_to_reg), .i_exmem_reg_write(i_exmem_reg_write),
        .i_exmem_wb_addr(i_exmem_wb_addr), .i_exmem_result(i_exmem_result),
        .i_memwb_reg_write(i_memwb_reg_write), .i_memwb_wb_addr(i_memwb_wb_addr),
        .i_memwb_data(i_memwb_data), .o_a(o_a), .o_b(o_b), .o_alu_op(o_alu_op),
        .o_store_data(o_store_data), .o_wb_addr(o_wb_addr), .o_reg_write(o_reg_write),
        .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_mem_to_reg(o_mem_to_reg),
        .o_valid(o_valid), .o_load_use(o_load_use)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic slot_t empty_slot();
        slot_t s;
        s = '{rs_data: 0, rt_data: 0, imm: 0, shamt: 0, rs_addr: 0, rt_addr: 0, wb_addr: 0,
              alu_op: 0, a_sel: 0, b_sel: 0, rw: 0, mr: 0, mw: 0, m2r: 0, v: 0};
        return s;
    endfunction

    // Value a source register has once newer in-flight writes are taken into account
    function automatic logic [31:0] newest(input logic [4:0] r, input logic [31:0] stale);
        if (r == 0) return stale;
        if (i_exmem_reg_write && i_exmem_wb_addr == r) return i_exmem_result;
        if (i_memwb_reg_write && i_memwb_wb_addr == r) return i_memwb_data;
        return stale;
    endfunction

    task automatic model_edge();
        if (i_reset || i_flush) m = empty_slot();
        else if (!i_stall)
            m = '{rs_data: i_rs_data, rt_data: i_rt_data, imm: i_imm, shamt: i_shamt,
                  rs_addr: i_rs_addr, rt_addr: i_rt_addr, wb_addr: i_wb_addr,
                  alu_op: i_alu_op, a_sel: i_a_sel, b_sel: i_b_sel, rw: i_reg_write,
                  mr: i_mem_read, mw: i_mem_write, m2r: i_mem_to_reg, v: i_valid};
    endtask

    task automatic check_all(input string tag);
        logic [31:0] rs, rt, b_choice [4];
        logic lu;
        rs = newest(m.rs_addr, m.rs_data);
        rt = newest(m.rt_addr, m.rt_data);
        b_choice[0] = rt;
        b_choice[1] = m.imm;
        b_choice[2] = 32'(m.shamt);
        b_choice[3] = rs;
        lu = i_valid && m.v && m.mr && m.wb_addr != 0 &&
             (m.wb_addr == i_rs_addr || m.wb_addr == i_rt_addr);
        chk({tag, ".a"}, o_a, m.a_sel ? rt : rs);
        chk({tag, ".b"}, o_b, b_choice[m.b_sel]);
        chk({tag, ".store"}, o_store_data, rt);
        chk({tag, ".alu_op"}, 32'(o_alu_op), 32'(m.alu_op));
        chk({tag, ".wb_addr"}, 32'(o_wb_addr), 32'(m.wb_addr));
        chk({tag, ".ctrl"}, 32'({o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_valid}),
            32'({m.rw & m.v, m.mr & m.v, m.mw & m.v, m.m2r & m.v, m.v}));
        chk({tag, ".load_use"}, 32'(o_load_use), 32'(lu));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        i_stall = 0; i_flush = 0; i_valid = 0;
        i_rs_data = 0; i_rt_data = 0; i_imm = 0; i_shamt = 0;
        i_rs_addr = 0; i_rt_addr = 0; i_wb_addr = 0; i_alu_op = 0;
        i_a_sel = 0; i_b_sel = 0;
        i_reg_write = 0; i_mem_read = 0; i_mem_write = 0; i_mem_to_reg = 0;
        i_exmem_reg_write = 0; i_exmem_wb_addr = 0; i_exmem_result = 0;
        i_memwb_reg_write = 0; i_memwb_wb_addr = 0; i_memwb_data = 0;
    endtask

    task automatic rand_inputs();
        i_stall = ($urandom_range(0, 7) == 0);
        i_flush = ($urandom_range(0, 7) == 0);
        i_valid = $urandom_range(0, 3) != 0;
        i_rs_data = $urandom; i_rt_data = $urandom; i_imm = $urandom;
        i_shamt = 5'($urandom);
        i_rs_addr = 5'($urandom_range(0, 3)); i_rt_addr = 5'($urandom_range(0, 3));
        i_wb_addr = 5'($urandom_range(0, 3)); i_alu_op = 4'($urandom);
        i_a_sel = 1'($urandom); i_b_sel = 2'($urandom);
        i_reg_write = 1'($urandom); i_mem_read = 1'($urandom);
        i_mem_write = 1'($urandom); i_mem_to_reg = 1'($urandom);
        i_exmem_reg_write = 1'($urandom); i_exmem_wb_addr = 5'($urandom_range(0, 3));
        i_exmem_result = $urandom;
        i_memwb_reg_write = 1'($urandom); i_memwb_wb_addr = 5'($urandom_range(0, 3));
        i_memwb_data = $urandom;
    endtask

    initial begin
        idle_inputs();
        i_reset = 1;
        m = empty_slot();
        #2;
        check_all("reset_init");
        @(posedge clk); #1;
        i_reset = 0;

        // Load something, then reset asynchronously between edges
        rand_inputs(); i_stall = 0; i_flush = 0; i_valid = 1;
        step();
        #2;
        i_reset = 1;
        m = empty_slot();
        #1;
        chk("reset_async.valid", 32'(o_valid), 0);
        chk("reset_async.a", o_a, 0);
        check_all("reset_async");
        step();
        i_reset = 0;
        #1;
        chk("reset_release.valid", 32'(o_valid), 0);

        // Plain pass-through
        idle_inputs();
        i_valid = 1; i_rs_addr = 5; i_rs_data = 10; i_rt_addr = 6; i_rt_data = 3;
        i_alu_op = 4'b0011; i_b_sel = 0;
        step();
        chk("pass.valid", 32'(o_valid), 1);
        chk("pass.a", o_a, 10);
        chk("pass.b", o_b, 3);
        chk("pass.alu_op", 32'(o_alu_op), 4'b0011);
        check_all("pass");

        // Forwarding priority
        idle_inputs();
        i_valid = 1; i_rs_addr = 4; i_rs_data = 32'h55;
        step();
        i_exmem_reg_write = 1; i_exmem_wb_addr = 4; i_exmem_result = 32'h11;
        i_memwb_reg_write = 1; i_memwb_wb_addr = 4; i_memwb_data = 32'h22;
        #1;
        chk("fwd.exmem", o_a, 32'h11);
        i_exmem_reg_write = 0;
        #1;
        chk("fwd.memwb", o_a, 32'h22);
        check_all("fwd.memwb");
        i_exmem_reg_write = 1; i_exmem_wb_addr = 0; i_memwb_wb_addr = 0;
        i_rs_addr = 0; i_rs_data = 32'h77;
        step();
        chk("fwd.r0", o_a, 32'h77);

        // Shift and immediate operands
        idle_inputs();
        i_valid = 1; i_a_sel = 1; i_b_sel = 2; i_rt_addr = 9; i_rt_data = 1; i_shamt = 4;
        step();
        chk("shift.a", o_a, 1);
        chk("shift.b", o_b, 4);
        i_b_sel = 1; i_imm = 32'hFFFF_FFF0;
        step();
        chk("imm.b", o_b, 32'hFFFF_FFF0);

        // Stall holds for three cycles while inputs churn
        idle_inputs();
        i_valid = 1; i_rs_addr = 2; i_rs_data = 32'hABCD; i_alu_op = 4'h9;
        i_reg_write = 1; i_mem_write = 1; i_wb_addr = 3;
        step();
        for (int k = 0; k < 3; k++) begin
            rand_inputs(); i_stall = 1; i_flush = 0;
            i_exmem_reg_write = 0; i_memwb_reg_write = 0;
            step();
            chk("stall.a", o_a, 32'hABCD);
            chk("stall.alu_op", 32'(o_alu_op), 4'h9);
            chk("stall.ctrl", 32'({o_reg_write, o_mem_write, o_valid}), 3'b111);
        end

        // Flush together with stall loads a bubble
        i_stall = 1; i_flush = 1;
        step();
        chk("flush.ctrl", 32'({o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_valid}), 0);
        check_all("flush");

        // Load-use detection
        idle_inputs();
        i_valid = 1; i_mem_read = 1; i_wb_addr = 7; i_reg_write = 1;
        step();
        i_valid = 1; i_rt_addr = 7; i_rs_addr = 1; i_mem_read = 0; i_wb_addr = 0;
        #1;
        chk("load_use.hit", 32'(o_load_use), 1);
        i_rt_addr = 0; i_mem_read = 1;
        step();
        i_rt_addr = 0; i_rs_addr = 0; i_mem_read = 0; i_wb_addr = 7;
        #1;
        chk("load_use.r0", 32'(o_load_use), 0);
        i_rt_addr = 7;
        step();
        #1;
        chk("load_use.noload", 32'(o_load_use), 0);

        // Randomized sequence against the reference slot
        for (int n = 0; n < 400; n++) begin
            rand_inputs();
            #1;
            check_all("rand");
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
